// File: rtl/id_ctrl_pipe.sv
// ID-stage control decoder with registered ID/EX control word, load-use freeze and branch flush FSM.
// Optional performance counters (stall_cnt, flush_cnt) are built only when CTRL_PERF_CNT_EN is defined.
module id_ctrl_pipe #(
    parameter int OP_W      = 6,
    parameter int EXE_W     = 4,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [OP_W-1:0]  opCode,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    output logic             branchEn,
    output logic [EXE_W-1:0] EXE_CMD,
    output logic [1:0]       Branch_command,
    output logic             Is_Imm,
    output logic             ST_or_BNE,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             ctrl_valid,
    output logic             freeze,
    output logic             flush,
    output logic             illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (FLUSH_CYC < 1 || FLUSH_CYC > 15 || CNT_W < 1) begin : g_param_check
        $error("id_ctrl_pipe: FLUSH_CYC must be 1..15 and CNT_W at least 1");
    end

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLA  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(32);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(33);
    localparam logic [OP_W-1:0] OP_LD   = OP_W'(36);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(37);
    localparam logic [OP_W-1:0] OP_BEZ  = OP_W'(40);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(41);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(42);

    localparam logic [EXE_W-1:0] EXE_ADD = EXE_W'(4'b0000);
    localparam logic [EXE_W-1:0] EXE_SUB = EXE_W'(4'b0010);
    localparam logic [EXE_W-1:0] EXE_AND = EXE_W'(4'b0100);
    localparam logic [EXE_W-1:0] EXE_OR  = EXE_W'(4'b0101);
    localparam logic [EXE_W-1:0] EXE_NOR = EXE_W'(4'b0110);
    localparam logic [EXE_W-1:0] EXE_XOR = EXE_W'(4'b0111);
    localparam logic [EXE_W-1:0] EXE_SLA = EXE_W'(4'b1000);
    localparam logic [EXE_W-1:0] EXE_SLL = EXE_W'(4'b1000);
    localparam logic [EXE_W-1:0] EXE_SRA = EXE_W'(4'b1001);
    localparam logic [EXE_W-1:0] EXE_SRL = EXE_W'(4'b1010);
    localparam logic [EXE_W-1:0] EXE_NOP = EXE_W'(4'b1111);

    localparam logic [1:0] COND_BNE  = 2'b01;
    localparam logic [1:0] COND_JUMP = 2'b10;
    localparam logic [1:0] COND_BEZ  = 2'b11;

    localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYC - 1);

    typedef struct packed {
        logic             valid;
        logic             branch_en;
        logic [EXE_W-1:0] exe_cmd;
        logic [1:0]       br_cmd;
        logic             is_imm;
        logic             st_or_bne;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
    } ctrl_t;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    ctrl_t      dec;
    logic       dec_legal;
    ctrl_t      ctrl_d, ctrl_q;
    logic       illegal_d, illegal_q;
    state_t     state_d, state_q;
    logic [3:0] fl_cnt_d, fl_cnt_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        unique case (opCode)
            OP_NOP:  ;
            OP_ADD:  begin dec.exe_cmd = EXE_ADD; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_SUB:  begin dec.exe_cmd = EXE_SUB; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_AND:  begin dec.exe_cmd = EXE_AND; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_OR:   begin dec.exe_cmd = EXE_OR;  dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_NOR:  begin dec.exe_cmd = EXE_NOR; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_XOR:  begin dec.exe_cmd = EXE_XOR; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_SLA:  begin dec.exe_cmd = EXE_SLA; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_SLL:  begin dec.exe_cmd = EXE_SLL; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_SRA:  begin dec.exe_cmd = EXE_SRA; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_SRL:  begin dec.exe_cmd = EXE_SRL; dec.wb_en = 1'b1; dec.valid = 1'b1; end
            OP_ADDI: begin
                dec.exe_cmd = EXE_ADD; dec.wb_en = 1'b1; dec.is_imm = 1'b1; dec.valid = 1'b1;
            end
            OP_SUBI: begin
                dec.exe_cmd = EXE_SUB; dec.wb_en = 1'b1; dec.is_imm = 1'b1; dec.valid = 1'b1;
            end
            OP_LD: begin
                dec.exe_cmd  = EXE_ADD; dec.wb_en = 1'b1; dec.is_imm = 1'b1;
                dec.st_or_bne = 1'b1;   dec.mem_r_en = 1'b1; dec.valid = 1'b1;
            end
            OP_ST: begin
                dec.exe_cmd  = EXE_ADD; dec.is_imm = 1'b1;
                dec.st_or_bne = 1'b1;   dec.mem_w_en = 1'b1; dec.valid = 1'b1;
            end
            OP_BEZ: begin
                dec.exe_cmd = EXE_NOP; dec.is_imm = 1'b1; dec.branch_en = 1'b1;
                dec.br_cmd  = COND_BEZ; dec.valid = 1'b1;
            end
            OP_BNE: begin
                dec.exe_cmd = EXE_NOP; dec.is_imm = 1'b1; dec.branch_en = 1'b1;
                dec.br_cmd  = COND_BNE; dec.st_or_bne = 1'b1; dec.valid = 1'b1;
            end
            OP_JMP: begin
                dec.exe_cmd = EXE_NOP; dec.is_imm = 1'b1; dec.branch_en = 1'b1;
                dec.br_cmd  = COND_JUMP; dec.valid = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Only a RUN cycle with no branch and no hazard lets a decoded instruction through.
    always_comb begin
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        ctrl_d    = '0;
        illegal_d = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    flush    = 1'b1;
                    fl_cnt_d = FL_LOAD;
                    if (FLUSH_CYC > 1) state_d = S_FLUSH;
                end else if (hazard_detected) begin
                    freeze = 1'b1;
                end else if (valid_in) begin
                    ctrl_d    = dec;
                    illegal_d = ~dec_legal;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (branch_taken) begin
                    fl_cnt_d = FL_LOAD;
                end else if (fl_cnt_q <= 4'd1) begin
                    fl_cnt_d = 4'd0;
                    state_d  = S_RUN;
                end else begin
                    fl_cnt_d = fl_cnt_q - 4'd1;
                end
            end
            default: state_d = S_RUN;
        endcase
        // Reset overrides the combinational handshakes as well as the registered word.
        if (!rst) begin
            freeze = 1'b0;
            flush  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_RUN;
            fl_cnt_q  <= 4'd0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fl_cnt_q  <= fl_cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign ctrl_valid     = ctrl_q.valid;
    assign branchEn       = ctrl_q.branch_en;
    assign EXE_CMD        = ctrl_q.exe_cmd;
    assign Branch_command = ctrl_q.br_cmd;
    assign Is_Imm         = ctrl_q.is_imm;
    assign ST_or_BNE      = ctrl_q.st_or_bne;
    assign WB_EN          = ctrl_q.wb_en;
    assign MEM_R_EN       = ctrl_q.mem_r_en;
    assign MEM_W_EN       = ctrl_q.mem_w_en;
    assign illegal_op     = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (freeze && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed self-checking bench for id_ctrl_pipe (FLUSH_CYC=3, CNT_W=3 so counter saturation is reachable).
// Counter checks are compiled in only when CTRL_PERF_CNT_EN is defined.
module tb_id_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [5:0] opCode;
    logic       hazard_detected;
    logic       branch_taken;
    logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
    logic [3:0] EXE_CMD;
    logic [1:0] Branch_command;
    logic       ctrl_valid, freeze, flush, illegal_op;
`ifdef CTRL_PERF_CNT_EN
    logic [2:0] stall_cnt, flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ctrl_pipe #(
        .OP_W(6), .EXE_W(4), .FLUSH_CYC(3), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opCode(opCode),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .branchEn(branchEn), .EXE_CMD(EXE_CMD), .Branch_command(Branch_command),
        .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ctrl_valid(ctrl_valid),
        .freeze(freeze), .flush(flush), .illegal_op(illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // Observed word: {ctrl_valid, branchEn, EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN}
    logic [12:0] word;
    assign word = {ctrl_valid, branchEn, EXE_CMD, Branch_command, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN};

    localparam logic [12:0] BUBBLE = 13'd0;

    function automatic logic [12:0] mk(input logic v, input logic br, input logic [3:0] exe,
                                       input logic [1:0] bc, input logic imm, input logic sob,
                                       input logic wb, input logic mr, input logic mw);
        return {v, br, exe, bc, imm, sob, wb, mr, mw};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one legal opcode for a cycle and check the word registered from it.
    task automatic dec_step(input string tag, input logic [5:0] op, input logic [12:0] exp);
        opCode = op;
        tick();
        check(tag, {19'd0, word}, {19'd0, exp});
        check({tag, "_ill"}, {31'd0, illegal_op}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b1; opCode = 6'd32; hazard_detected = 1'b1; branch_taken = 1'b1;
        #1;
        // Reset dominates branch/hazard, combinationally and at the edge.
        check("rst_freeze_comb", {31'd0, freeze}, 32'd0);
        check("rst_flush_comb", {31'd0, flush}, 32'd0);
        tick();
        check("rst_word", {19'd0, word}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        tick();
        check("rst_word2", {19'd0, word}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        check("rst_flush_cnt", {29'd0, flush_cnt}, 32'd0);
`endif

        // ADDI right after reset.
        rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
        #1;
        check("run_flush_comb", {31'd0, flush}, 32'd0);
        check("run_freeze_comb", {31'd0, freeze}, 32'd0);
        dec_step("addi", 6'd32, mk(1, 0, 4'd0, 2'd0, 1, 0, 1, 0, 0));

        // Opcode table.
        dec_step("add",  6'd1,  mk(1, 0, 4'd0,  2'd0, 0, 0, 1, 0, 0));
        dec_step("sub",  6'd3,  mk(1, 0, 4'd2,  2'd0, 0, 0, 1, 0, 0));
        dec_step("and",  6'd5,  mk(1, 0, 4'd4,  2'd0, 0, 0, 1, 0, 0));
        dec_step("or",   6'd6,  mk(1, 0, 4'd5,  2'd0, 0, 0, 1, 0, 0));
        dec_step("nor",  6'd7,  mk(1, 0, 4'd6,  2'd0, 0, 0, 1, 0, 0));
        dec_step("xor",  6'd8,  mk(1, 0, 4'd7,  2'd0, 0, 0, 1, 0, 0));
        dec_step("sla",  6'd9,  mk(1, 0, 4'd8,  2'd0, 0, 0, 1, 0, 0));
        dec_step("sll",  6'd10, mk(1, 0, 4'd8,  2'd0, 0, 0, 1, 0, 0));
        dec_step("sra",  6'd11, mk(1, 0, 4'd9,  2'd0, 0, 0, 1, 0, 0));
        dec_step("srl",  6'd12, mk(1, 0, 4'd10, 2'd0, 0, 0, 1, 0, 0));
        dec_step("subi", 6'd33, mk(1, 0, 4'd2,  2'd0, 1, 0, 1, 0, 0));
        dec_step("st",   6'd37, mk(1, 0, 4'd0,  2'd0, 1, 1, 0, 0, 1));
        dec_step("bez",  6'd40, mk(1, 1, 4'd15, 2'd3, 1, 0, 0, 0, 0));
        dec_step("bne",  6'd41, mk(1, 1, 4'd15, 2'd1, 1, 1, 0, 0, 0));
        dec_step("jmp",  6'd42, mk(1, 1, 4'd15, 2'd2, 1, 0, 0, 0, 0));

        // valid_in low gives a bubble even for a legal opcode.
        valid_in = 1'b0;
        dec_step("invalid", 6'd1, BUBBLE);
        valid_in = 1'b1;

        // Load-use: LD, then the next instruction held under hazard for two cycles.
        dec_step("ld", 6'd36, mk(1, 0, 4'd0, 2'd0, 1, 1, 1, 1, 0));
        opCode = 6'd1; hazard_detected = 1'b1;
        #1;
        check("haz1_freeze", {31'd0, freeze}, 32'd1);
        check("haz1_flush", {31'd0, flush}, 32'd0);
        tick();
        check("haz1_bubble", {19'd0, word}, 32'd0);
        check("haz2_freeze", {31'd0, freeze}, 32'd1);
        tick();
        check("haz2_bubble", {19'd0, word}, 32'd0);
        hazard_detected = 1'b0;
        #1;
        check("haz_release_freeze", {31'd0, freeze}, 32'd0);
        dec_step("haz_held_add", 6'd1, mk(1, 0, 4'd0, 2'd0, 0, 0, 1, 0, 0));
`ifdef CTRL_PERF_CNT_EN
        check("stall_cnt_2", {29'd0, stall_cnt}, 32'd2);
`endif

        // Taken branch with FLUSH_CYC=3: flush for cycles 0..2, three bubbles.
        branch_taken = 1'b1;
        #1;
        check("br_c0_flush", {31'd0, flush}, 32'd1);
        tick();
        branch_taken = 1'b0;
        check("br_c1_bubble", {19'd0, word}, 32'd0);
        check("br_c1_flush", {31'd0, flush}, 32'd1);
        tick();
        check("br_c2_bubble", {19'd0, word}, 32'd0);
        check("br_c2_flush", {31'd0, flush}, 32'd1);
        tick();
        check("br_c3_bubble", {19'd0, word}, 32'd0);
        check("br_c3_flush", {31'd0, flush}, 32'd0);
        dec_step("br_resume", 6'd1, mk(1, 0, 4'd0, 2'd0, 0, 0, 1, 0, 0));
`ifdef CTRL_PERF_CNT_EN
        check("flush_cnt_3", {29'd0, flush_cnt}, 32'd3);
`endif

        // Branch and hazard together: branch wins, no freeze.
        branch_taken = 1'b1; hazard_detected = 1'b1;
        #1;
        check("bh_freeze", {31'd0, freeze}, 32'd0);
        check("bh_flush", {31'd0, flush}, 32'd1);
        tick();
        branch_taken = 1'b0; hazard_detected = 1'b0;
        check("bh_bubble", {19'd0, word}, 32'd0);
        tick();
        tick();
        check("bh_c3_flush", {31'd0, flush}, 32'd0);
        dec_step("bh_resume", 6'd1, mk(1, 0, 4'd0, 2'd0, 0, 0, 1, 0, 0));
`ifdef CTRL_PERF_CNT_EN
        check("bh_stall_cnt", {29'd0, stall_cnt}, 32'd2);
        check("flush_cnt_6", {29'd0, flush_cnt}, 32'd6);
`endif

        // Undefined opcodes pulse illegal_op once; NOP is a silent bubble.
        opCode = 6'h3F;
        tick();
        check("ill3f_word", {19'd0, word}, 32'd0);
        check("ill3f_pulse", {31'd0, illegal_op}, 32'd1);
        dec_step("after_ill_add", 6'd1, mk(1, 0, 4'd0, 2'd0, 0, 0, 1, 0, 0));
        opCode = 6'h02;
        tick();
        check("ill02_pulse", {31'd0, illegal_op}, 32'd1);
        dec_step("nop", 6'd0, BUBBLE);

        // Branch again during FLUSH restarts the count: flush spans cycles 0..3.
        opCode = 6'd1; branch_taken = 1'b1;
        tick();
        check("rs_c1_flush", {31'd0, flush}, 32'd1);
        tick();
        branch_taken = 1'b0;
        tick();
        check("rs_c3_flush", {31'd0, flush}, 32'd1);
        check("rs_c3_bubble", {19'd0, word}, 32'd0);
        tick();
        check("rs_c4_flush", {31'd0, flush}, 32'd0);
        dec_step("rs_resume", 6'd1, mk(1, 0, 4'd0, 2'd0, 0, 0, 1, 0, 0));
`ifdef CTRL_PERF_CNT_EN
        check("flush_cnt_sat", {29'd0, flush_cnt}, 32'd7);
`endif

        // Reset during the second flush cycle aborts the flush.
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0; rst = 1'b0;
        #1;
        check("rf_flush_comb", {31'd0, flush}, 32'd0);
        tick();
        rst = 1'b1;
        check("rf_word", {19'd0, word}, 32'd0);
        check("rf_flush", {31'd0, flush}, 32'd0);
        check("rf_illegal", {31'd0, illegal_op}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("rf_stall_cnt", {29'd0, stall_cnt}, 32'd0);
        check("rf_flush_cnt", {29'd0, flush_cnt}, 32'd0);
`endif
        dec_step("rf_resume_ld", 6'd36, mk(1, 0, 4'd0, 2'd0, 1, 1, 1, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ctrl_pipe.md
ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have parameter EXE_W, default 4, EXE_CMD width.
REQ-003 SHALL have parameter FLUSH_CYC, default 1, bubble cycles after a taken branch; legal range 1..15.
REQ-004 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-005 SHALL have port clk input 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst input 1, synchronous, active-low reset.
REQ-007 SHALL have port valid_in input 1, the ID stage holds a real instruction.
REQ-008 SHALL have port opCode input OP_W, instruction opcode.
REQ-009 SHALL have port hazard_detected input 1, load-use hazard from the hazard unit.
REQ-010 SHALL have port branch_taken input 1, EXE stage resolved a taken branch or jump.
REQ-011 SHALL have registered outputs branchEn 1, EXE_CMD EXE_W, Branch_command 2, Is_Imm 1, ST_or_BNE 1, WB_EN 1, MEM_R_EN 1, MEM_W_EN 1, forming the ID/EX control word.
REQ-012 SHALL have port ctrl_valid output 1, the control word is a real instruction and not a bubble.
REQ-013 SHALL have port freeze output 1, hold PC and IF/ID.
REQ-014 SHALL have port flush output 1, clear IF/ID.
REQ-015 SHALL have port illegal_op output 1, one-cycle pulse on an undefined opcode.
REQ-016 SHALL have ports stall_cnt and flush_cnt output CNT_W each; present only under REQ-033.

Function
REQ-017 SHALL decode, per the project opcode table:
- R-type ADD/SUB/AND/OR/NOR/XOR/SLA/SLL/SRA/SRL: matching EXE op, WB_EN.
- ADDI/SUBI: EXE add/sub, WB_EN, Is_Imm.
- LD: add, WB_EN, Is_Imm, ST_or_BNE, MEM_R_EN.
- ST: add, Is_Imm, ST_or_BNE, MEM_W_EN.
- BEZ/BNE/JMP: EXE no-op, Is_Imm, branchEn, COND_BEZ/COND_BNE/COND_JUMP; BNE also sets ST_or_BNE.
REQ-018 SHALL define a bubble as every control-word bit 0 and ctrl_valid 0.
REQ-019 SHALL register the decoded word one cycle after valid_in and opCode are presented (latency 1).
REQ-020 SHALL implement FSM states RUN and FLUSH, with a down-counter fl_cnt of 4 bits.
REQ-021 In RUN with branch_taken=1, SHALL register a bubble, set flush=1, load fl_cnt=FLUSH_CYC-1, and go to FLUSH when FLUSH_CYC>1, otherwise stay in RUN.
REQ-022 In FLUSH, SHALL register a bubble, keep flush=1, and decrement fl_cnt; at fl_cnt=0 it SHALL return to RUN with flush deasserted the following cycle.
REQ-023 branch_taken during FLUSH SHALL reload fl_cnt=FLUSH_CYC-1 (restart).
REQ-024 In RUN with hazard_detected=1 and branch_taken=0, SHALL register a bubble; freeze SHALL equal hazard_detected combinationally in the same cycle.
REQ-025 SHALL hold freeze at 0 in FLUSH and whenever branch_taken=1; branch_taken has priority over hazard_detected.
REQ-026 valid_in=0 SHALL register a bubble.
REQ-027 An undefined opcode with valid_in=1 SHALL register a bubble and pulse illegal_op for exactly 1 cycle (registered); opcode 0 is NOP, a legal bubble with no pulse.

Reset
REQ-028 With rst=0 at a clock edge, all outputs SHALL be 0, state RUN, and fl_cnt 0, counters included.
REQ-029 Reset mid-FLUSH SHALL abort the flush; flush=0 on the next cycle.
REQ-030 Reset SHALL take priority over branch_taken and hazard_detected.

Configuration
REQ-031 Macro CTRL_PERF_CNT_EN SHALL gate the performance counters.
REQ-032 Without the macro, the stall_cnt and flush_cnt ports and their logic SHALL not exist.
REQ-033 With the macro, stall_cnt SHALL increment on each cycle freeze=1 and flush_cnt on each cycle flush=1; both saturate at all-ones and clear on reset.

Verification
REQ-034 Reset then ADDI with valid_in=1 -> next cycle EXE_CMD=add, WB_EN=1, Is_Imm=1, ctrl_valid=1, other bits 0.
REQ-035 LD, then hazard_detected=1 for 2 cycles -> freeze=1 for 2 cycles, 2 bubbles, then the held instruction decodes; stall_cnt=2 with the macro.
REQ-036 FLUSH_CYC=3, branch_taken=1 for 1 cycle -> flush=1 for exactly 3 cycles, 3 bubbles, back in RUN; flush_cnt=3.
REQ-037 branch_taken and hazard_detected asserted together -> freeze=0, flush=1, bubble.
REQ-038 Undefined opcode 6'h3F -> bubble and a single illegal_op pulse; opcode 0 -> bubble with no pulse.
REQ-039 rst=0 during the second FLUSH cycle -> all outputs 0 next cycle, then normal decode resumes.
